xeng_feeder: RTL

//  Transmit-side feeder for the X-engine: accepts corner-turned samples in time-major order (per time step, all antennas)

---
 rtl/xeng_feeder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/xeng_feeder.sv
// Ping-pong transpose buffer feeding the X-engine: time-major words in, antenna-major windows out with vld/sync/mcnt.
// Optional mcnt continuity checker is compiled in when XENG_FEEDER_MCNT_CHECK_EN is defined.
module xeng_feeder #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int BITWIDTH            = 4,
  parameter int N_ANTS              = 64,
  parameter int MCNT_WIDTH          = 48,
  parameter int BRAM_LATENCY        = 2,
  localparam int W = 2 * BITWIDTH * 2 * (1 << P_FACTOR_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MCNT_WIDTH-1:0] in_mcnt,
  output logic [W-1:0]          din,
  output logic                  vld,
  output logic                  sync,
  output logic [MCNT_WIDTH-1:0] mcnt
`ifdef XENG_FEEDER_MCNT_CHECK_EN
  ,
  output logic                  mcnt_err,
  output logic [15:0]           mcnt_err_cnt
`endif
);

  localparam int ANT_BITS = $clog2(N_ANTS);
  localparam int WIN_BITS = SERIAL_ACC_LEN_BITS + ANT_BITS;
  localparam int DEPTH    = 2 << WIN_BITS;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                           state_q, state_d;
  logic                             rbank_q, rbank_d;
  logic                             wbank_q, wbank_d;
  logic [1:0]                       full_q, full_d;
  logic [WIN_BITS-1:0]              wr_cnt_q, wr_cnt_d;
  logic [WIN_BITS-1:0]              rd_cnt_q, rd_cnt_d;
  logic [1:0][MCNT_WIDTH-1:0]       bank_mcnt_q, bank_mcnt_d;
  logic [MCNT_WIDTH-1:0]            mcnt_q, mcnt_d;
  logic                             rdy_en_q, rdy_en_d;
  logic [BRAM_LATENCY-1:0]          vld_pipe_q, vld_pipe_d;

  logic                             wr_en;
  logic                             rd_issue;
  logic                             rd_last;
  logic                             sync_c;
  logic [WIN_BITS:0]                wr_addr;
  logic [WIN_BITS:0]                rd_addr;

  logic [W-1:0]                     mem [DEPTH];
  logic [W-1:0]                     rd_dat_q [1:BRAM_LATENCY];

  assign in_ready = rdy_en_q & ~full_q[wbank_q];
  assign wr_en    = in_valid & in_ready;

  // Write order is ant-inner, read order is t-inner: swapping the fields does the transpose.
  assign wr_addr = {wbank_q, wr_cnt_q[ANT_BITS-1:0], wr_cnt_q[WIN_BITS-1:ANT_BITS]};
  assign rd_addr = {rbank_q, rd_cnt_q};

  always_comb begin
    state_d     = state_q;
    rbank_d     = rbank_q;
    wbank_d     = wbank_q;
    full_d      = full_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    bank_mcnt_d = bank_mcnt_q;
    rdy_en_d    = 1'b1;

    // IDLE issues the first read in the same cycle it sees a full bank.
    rd_issue = (state_q == S_STREAM) || full_q[rbank_q];
    rd_last  = rd_issue && (rd_cnt_q == '1);

    if (rd_issue) begin
      rd_cnt_d = rd_cnt_q + WIN_BITS'(1);
      state_d  = S_STREAM;
    end
    if (rd_last) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      state_d         = full_q[~rbank_q] ? S_STREAM : S_IDLE;
    end

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + WIN_BITS'(1);
      if (wr_cnt_q == '0) begin
        bank_mcnt_d[wbank_q] = in_mcnt;
      end
      if (wr_cnt_q == '1) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // Reads within a window are gap-free, so the read issued BRAM_LATENCY-1 slots after the
    // first one lines up exactly with the cycle before the first word leaves the pipe.
    // rbank cannot have toggled yet at that point, so it still names the window's bank.
    sync_c = rd_issue && (rd_cnt_q == WIN_BITS'(BRAM_LATENCY - 1));
    mcnt_d = sync_c ? bank_mcnt_q[rbank_q] : mcnt_q;

    vld_pipe_d = (vld_pipe_q << 1) | BRAM_LATENCY'(rd_issue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rbank_q     <= 1'b0;
      wbank_q     <= 1'b0;
      full_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      bank_mcnt_q <= '0;
      mcnt_q      <= '0;
      rdy_en_q    <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_mcnt_q <= bank_mcnt_d;
      mcnt_q      <= mcnt_d;
      rdy_en_q    <= rdy_en_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
    rd_dat_q[1] <= mem[rd_addr];
    for (int i = 2; i <= BRAM_LATENCY; i++) begin
      rd_dat_q[i] <= rd_dat_q[i-1];
    end
  end

  assign vld  = vld_pipe_q[BRAM_LATENCY-1];
  assign din  = vld ? rd_dat_q[BRAM_LATENCY] : '0;
  assign sync = sync_c;
  assign mcnt = mcnt_d;

`ifdef XENG_FEEDER_MCNT_CHECK_EN
  logic        seen_q, seen_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    seen_d    = seen_q | sync_c;
    mcnt_err  = sync_c && seen_q && (mcnt_d != mcnt_q + MCNT_WIDTH'(1));
    err_cnt_d = err_cnt_q;
    if (mcnt_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seen_q    <= seen_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mcnt_err_cnt = err_cnt_q;
`else
  // mcnt is forwarded without continuity checking.
`endif

endmodule
